alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between NREQ requesters, e.g. the execute stage and the branch/address unit.
//  Each requester presents an op through a valid/ready handshake. The block round-robin arbitrates,
//  drives the ALU sel/a/b ports, and registers result plus flags {z,s,c,v} into a one-deep response slot.
//  An optional per-requester lock holds the grant across a multi-op sequence.
// PARAMETERS
//  NREQ   2   number of requesters, 2..8
//  IDW    $clog2(NREQ) (min 1)   width of requester id
// PORTS
//  clk          in   1         single clock, all state updates on rising edge
//  rst          in   1         synchronous reset, active-high
//  req_valid    in   NREQ      requester i has an op pending
//  req_lock     in   NREQ      requester i asks to keep the grant after this op
//  req_sel      in   NREQ*4    ALU opcode per requester (slice i = [4i+3:4i])
//  req_a        in   NREQ*32   operand A per requester
//  req_b        in   NREQ*32   operand B per requester
//  req_ready    out  NREQ      one-hot grant; op accepted when valid&ready at the clock edge
//  alu_sel      out  4         to ALU sel
//  alu_a        out  32        to ALU a
//  alu_b        out  32        to ALU b
//  alu_result   in   32        from ALU
//  alu_flags    in   4         from ALU {z,s,c,v}
//  rsp_valid    out  1         response slot full
//  rsp_id       out  IDW       requester that issued the op
//  rsp_result   out  32        registered ALU result
//  rsp_flags    out  4         registered {z,s,c,v}
//  rsp_ready    in   1         consumer takes the response when valid&ready
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rr_ptr=0, lock_own=none. req_ready=0 during rst.
//  - slot_free = !rsp_valid | rsp_ready. No grant is issued unless slot_free.
//  - Priority when lock_own=none: search starts at rr_ptr and goes upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
//    The first requester with valid wins.
//  - Priority when lock_own=k: only requester k may be granted. Other requesters stall even if k is idle.
//  - Grant is combinational from the current state: req_ready = onehot(winner) & {NREQ{slot_free}}.
//  - Mux: alu_sel/a/b = the winner's fields. With no winner, drive alu_sel=`ALU_PASS and a=b=0.
//  - On an accept edge:
//    - rsp_valid<=1, rsp_id<=winner, rsp_result<=alu_result, rsp_flags<=alu_flags.
//    - rr_ptr<=winner+1, wrapping to 0 at NREQ.
//    - lock_own<=winner if req_lock[winner], else none.
//  - Latency: op accepted at edge N is visible on rsp_* after edge N (1 cycle). Throughput is 1 op/cycle while rsp_ready=1.
//  - Drain without a new accept: rsp_valid<=0. rsp_result, rsp_id and rsp_flags hold their old values.
//  - Backpressure: while rsp_valid=1 and rsp_ready=0, the response holds stable, all req_ready=0, and rr_ptr/lock_own hold.
//  - Simultaneous drain and accept on one edge: the slot is overwritten with the new op and rsp_valid stays 1. No bubble.
//  - Lock release: the owner's accepted op with req_lock=0 clears lock_own. Normal RR resumes from winner+1 on the next cycle.
//  - Invalid sel (no matching ALU code): passed through unchanged. The ALU returns 0, which is captured as normal.
//  - Requesters must hold their fields stable while valid=1 and ready=0. The block does not check this.
//  - Reset mid-operation: any pending response is discarded and the lock is dropped.
// STRUCTURE
//  - The `ALU_* opcode constants and the FLAG_Z/S/C/V bit indices belong in the shared ALU defines file.
//    This block and the decoder include it.
//  - Sub-module rr_picker: combinational; inputs req, ptr and lock_own; outputs onehot winner and index.
//    rr_ptr, lock_own, the response register and the operand mux stay in the top.
// TESTING
//  1. Reset, then a single op: req0 ADD a=5,b=7, rsp_ready=1 -> after 1 edge rsp_valid=1, id=0, result=12, flags z=0.
//  2. Contention: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1.
//     req1 SUB 3-3 -> result=0, z=1.
//  3. Backpressure: rsp_ready=0 for 3 cycles with both requesters valid -> rsp holds, req_ready=0, rr_ptr unchanged.
//     Releasing rsp_ready -> next grant resumes in RR order.
//  4. Lock: req0 lock=1 for 3 ops while req1 is valid throughout -> 3 consecutive id=0 responses.
//     req0 lock=0 on the 4th op -> next grant goes to 1.
//  5. Wrap: NREQ=4, rr_ptr=3, req_valid=4'b0101 -> requester 0 is granted.
//     A 0x7FFFFFFF+1 ADD by requester 2 gives result=0x80000000 with v=1, s=1.
//  6. Reset mid-op: assert rst with rsp_valid=1 and lock held -> next cycle all outputs are 0 and lock_own=none.
//     The first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg
//   Shared ALU opcode and flag definitions for the ALU sharing arbiter and
//   anything that talks to the same ALU (decoder, testbench).
//   Flags are packed as {z,s,c,v}; FLAG_* give the bit positions.
package alu_share_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int FLAG_W = 4;

    // ALU opcodes. Codes not listed here are invalid: the ALU returns 0.
    localparam logic [SEL_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [SEL_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [SEL_W-1:0] ALU_AND  = 4'h2;
    localparam logic [SEL_W-1:0] ALU_OR   = 4'h3;
    localparam logic [SEL_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [SEL_W-1:0] ALU_SLL  = 4'h5;
    localparam logic [SEL_W-1:0] ALU_SRL  = 4'h6;
    localparam logic [SEL_W-1:0] ALU_PASS = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Requester-id width: ceil(log2(n)), never below 1.
    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// alu_share_arbiter_rr_picker
//   Combinational round-robin picker with lock override.
//   Ports:
//     req        in   NREQ  request vector
//     ptr        in   IDW   round-robin start position
//     lock_vld   in   1     a lock owner exists
//     lock_id    in   IDW   lock owner; only it is eligible while lock_vld
//     gnt        out  NREQ  one-hot winner (0 when none)
//     idx        out  IDW   winner index (0 when none)
//     found      out  1     a winner exists
module alu_share_arbiter_rr_picker
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = idw_of(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            lock_vld,
    input  logic [IDW-1:0]  lock_id,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    logic [NREQ-1:0] elig;
    logic [IDW:0]    pos;  // one spare bit so ptr+offset cannot overflow before the wrap

    always_comb begin
        elig  = req;
        if (lock_vld) elig = req & (NREQ'(1) << lock_id);
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        // Walk ptr, ptr+1, ... with wrap at NREQ; first eligible requester wins.
        for (int off = 0; off < NREQ; off++) begin
            pos = {1'b0, ptr} + (IDW+1)'(off);
            if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
            if (!found && elig[pos[IDW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDW-1:0];
            end
        end
        if (found) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between NREQ requesters. Round-robin grant
//   (with optional per-requester lock), operand mux to the ALU, and a
//   one-deep registered response slot for result + {z,s,c,v}.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/lock           per-requester op pending / keep grant after this op
//     req_sel/a/b              per-requester opcode and operands
//     req_ready                one-hot grant, 0 while the slot is blocked or in reset
//     alu_sel/a/b              to the shared ALU
//     alu_result/flags         from the shared ALU
//     rsp_valid/id/result/flags  response slot
//     rsp_ready                consumer accepts the response
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = idw_of(NREQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NREQ-1:0]                    req_valid,
    input  logic [NREQ-1:0]                    req_lock,
    input  logic [NREQ-1:0][SEL_W-1:0]         req_sel,
    input  logic [NREQ-1:0][DATA_W-1:0]        req_a,
    input  logic [NREQ-1:0][DATA_W-1:0]        req_b,
    output logic [NREQ-1:0]                    req_ready,
    output logic [SEL_W-1:0]                   alu_sel,
    output logic [DATA_W-1:0]                  alu_a,
    output logic [DATA_W-1:0]                  alu_b,
    input  logic [DATA_W-1:0]                  alu_result,
    input  logic [FLAG_W-1:0]                  alu_flags,
    output logic                               rsp_valid,
    output logic [IDW-1:0]                     rsp_id,
    output logic [DATA_W-1:0]                  rsp_result,
    output logic [FLAG_W-1:0]                  rsp_flags,
    input  logic                               rsp_ready
);

    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              lock_vld_q, lock_vld_d;
    logic [IDW-1:0]    lock_id_q, lock_id_d;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    win;
    logic              found;
    logic              slot_free;
    logic              accept;

    alu_share_arbiter_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .lock_vld (lock_vld_q),
        .lock_id  (lock_id_q),
        .gnt      (gnt),
        .idx      (win),
        .found    (found)
    );

    // Draining and refilling on the same edge is allowed, so a full slot
    // still frees up when the consumer is taking it this cycle.
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign accept    = found && slot_free && !rst;
    assign req_ready = accept ? gnt : '0;

    always_comb begin
        alu_sel = ALU_PASS;
        alu_a   = '0;
        alu_b   = '0;
        if (found) begin
            alu_sel = req_sel[win];
            alu_a   = req_a[win];
            alu_b   = req_b[win];
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rr_ptr_d     = rr_ptr_q;
        lock_vld_d   = lock_vld_q;
        lock_id_d    = lock_id_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = win;
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            rr_ptr_d     = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
            lock_vld_d   = req_lock[win];
            lock_id_d    = win;
        end else if (rsp_ready) begin
            // Drain only: payload fields keep their last values.
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rr_ptr_q     <= '0;
            lock_vld_q   <= 1'b0;
            lock_id_q    <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_vld_q   <= lock_vld_d;
            lock_id_q    <= lock_id_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter (NREQ=4): directed vector table for the
// handshake/lock/wrap/reset corners, then randomized traffic against a
// behavioural model of the arbitration rules.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_valid, req_lock, req_ready;
    logic [N-1:0][3:0]     req_sel;
    logic [N-1:0][31:0]    req_a, req_b;
    logic [3:0]            alu_sel;
    logic [31:0]           alu_a, alu_b, alu_result;
    logic [3:0]            alu_flags;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [31:0]           rsp_result;
    logic [3:0]            rsp_flags;
    logic                  rsp_ready;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(N), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_ready(rsp_ready)
    );

    // Reference ALU: returns {z,s,c,v, result}. c on SUB is borrow (a<b).
    function automatic logic [35:0] alu_ref(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic c, v, ok;
        w = '0; r = '0; c = 1'b0; v = 1'b0; ok = 1'b1;
        case (sel)
            ALU_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                           v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB: begin r = a - b; c = (a < b);
                           v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_PASS: r = a;
            default:  ok = 1'b0;
        endcase
        if (!ok) return 36'h0;
        return {(r == 32'h0), r[31], c, v, r};
    endfunction

    assign {alu_flags, alu_result} = alu_ref(alu_sel, alu_a, alu_b);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  v, l;
        bit          rdy;
        logic [3:0]  sel;
        logic [31:0] a, b;
        logic [3:0]  e_rdy;
        bit          e_rv;
        int          e_id;
        logic [31:0] e_res;
        logic [3:0]  e_flg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input logic [3:0] v, input logic [3:0] l, input bit rdy,
                       input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] e_rdy, input bit e_rv, input int e_id,
                       input logic [31:0] e_res, input logic [3:0] e_flg);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.rdy = rdy; t.sel = sel; t.a = a; t.b = b;
        t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_id = e_id; t.e_res = e_res; t.e_flg = e_flg;
        tbl.push_back(t);
    endtask

    // Behavioural model state (lock -1 = no owner)
    int          m_ptr, m_lock, m_id;
    bit          m_rv;
    logic [31:0] m_res;
    logic [3:0]  m_flg;

    initial begin
        rst = 1'b1; req_valid = '0; req_lock = '0; req_sel = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1;

        //   rst v       l       rdy sel       a             b     e_rdy   rv id res           flg
        add(1, 4'b0000, 4'b0000, 1, ALU_ADD, 0,            0,    4'b0000, 0, 0, 0,            4'b0000);
        add(0, 4'b0001, 4'b0000, 1, ALU_ADD, 5,            7,    4'b0001, 1, 0, 12,           4'b0000);
        add(0, 4'b0011, 4'b0000, 1, ALU_SUB, 3,            3,    4'b0010, 1, 1, 0,            4'b1000);
        add(0, 4'b0011, 4'b0000, 1, ALU_SUB, 3,            3,    4'b0001, 1, 0, 0,            4'b1000);
        add(0, 4'b0011, 4'b0000, 1, ALU_SUB, 3,            3,    4'b0010, 1, 1, 0,            4'b1000);
        // backpressure: three held cycles, then RR resumes at 0
        add(0, 4'b0011, 4'b0000, 0, ALU_ADD, 1,            1,    4'b0000, 1, 1, 0,            4'b1000);
        add(0, 4'b0011, 4'b0000, 0, ALU_ADD, 1,            1,    4'b0000, 1, 1, 0,            4'b1000);
        add(0, 4'b0011, 4'b0000, 0, ALU_ADD, 1,            1,    4'b0000, 1, 1, 0,            4'b1000);
        add(0, 4'b0011, 4'b0000, 1, ALU_ADD, 1,            1,    4'b0001, 1, 0, 2,            4'b0000);
        // lock held by 0 for three ops; owner idle stalls 1; release on 4th op
        add(0, 4'b0001, 4'b0001, 1, ALU_ADD, 1,            1,    4'b0001, 1, 0, 2,            4'b0000);
        add(0, 4'b0011, 4'b0001, 1, ALU_ADD, 2,            3,    4'b0001, 1, 0, 5,            4'b0000);
        add(0, 4'b0011, 4'b0001, 1, ALU_ADD, 2,            3,    4'b0001, 1, 0, 5,            4'b0000);
        add(0, 4'b0010, 4'b0001, 1, ALU_ADD, 2,            3,    4'b0000, 0, 0, 5,            4'b0000);
        add(0, 4'b0011, 4'b0000, 1, ALU_ADD, 4,            4,    4'b0001, 1, 0, 8,            4'b0000);
        add(0, 4'b0011, 4'b0000, 1, ALU_ADD, 4,            4,    4'b0010, 1, 1, 8,            4'b0000);
        // overflow by 2, then wrap from ptr=3 to requester 0
        add(0, 4'b0100, 4'b0000, 1, ALU_ADD, 32'h7FFFFFFF, 1,    4'b0100, 1, 2, 32'h80000000, 4'b0101);
        add(0, 4'b0101, 4'b0000, 1, ALU_ADD, 1,            2,    4'b0001, 1, 0, 3,            4'b0000);
        // invalid opcode: ALU returns 0, captured normally
        add(0, 4'b1010, 4'b0000, 1, 4'h9,    5,            5,    4'b0010, 1, 1, 0,            4'b0000);
        // reset with a held lock and a full slot; first grant afterwards is 0
        add(0, 4'b0010, 4'b0010, 1, ALU_ADD, 2,            2,    4'b0010, 1, 1, 4,            4'b0000);
        add(1, 4'b0011, 4'b0000, 0, ALU_ADD, 2,            2,    4'b0000, 0, 0, 0,            4'b0000);
        add(0, 4'b1111, 4'b0000, 1, ALU_ADD, 9,            9,    4'b0001, 1, 0, 18,           4'b0000);
        add(1, 4'b0000, 4'b0000, 1, ALU_ADD, 0,            0,    4'b0000, 0, 0, 0,            4'b0000);

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; req_valid = tbl[i].v; req_lock = tbl[i].l; rsp_ready = tbl[i].rdy;
            for (int k = 0; k < N; k++) begin
                req_sel[k] = tbl[i].sel; req_a[k] = tbl[i].a; req_b[k] = tbl[i].b;
            end
            #1;
            chk($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d rsp_valid", i),  64'(rsp_valid),  64'(tbl[i].e_rv));
            chk($sformatf("v%0d rsp_id", i),     64'(rsp_id),     64'(tbl[i].e_id));
            chk($sformatf("v%0d rsp_result", i), 64'(rsp_result), 64'(tbl[i].e_res));
            chk($sformatf("v%0d rsp_flags", i),  64'(rsp_flags),  64'(tbl[i].e_flg));
            @(negedge clk);
        end

        // Hand sequence: idle requesters -> ALU driven with PASS and zero operands.
        rst = 1'b0; req_valid = '0; req_a = '1; req_b = '1; #1;
        chk("idle alu_sel", 64'(alu_sel), 64'(ALU_PASS));
        chk("idle alu_a",   64'(alu_a),   64'h0);
        chk("idle alu_b",   64'(alu_b),   64'h0);

        // Randomized phase; the table ended in reset so the model starts clean.
        m_ptr = 0; m_lock = -1; m_rv = 1'b0; m_id = 0; m_res = '0; m_flg = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int pick, gnt, r;
            bit free;
            logic [35:0] fr;
            logic [3:0]  e_rdy;
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = 4'($urandom);
            req_lock  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                r = $urandom_range(0, 9);
                req_sel[k] = (r <= 6) ? 4'(r) : (r == 7) ? ALU_PASS : 4'($urandom);
                req_a[k] = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
                req_b[k] = ($urandom_range(0, 7) == 0) ? 32'h1 : $urandom;
            end
            #1;
            pick = -1;
            if (m_lock >= 0) begin
                if (req_valid[m_lock]) pick = m_lock;
            end else begin
                for (int k = 0; k < N; k++)
                    if (pick < 0 && req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            end
            free  = !m_rv || rsp_ready;
            gnt   = (free && !rst) ? pick : -1;
            e_rdy = (gnt >= 0) ? 4'(1 << gnt) : 4'b0;
            chk("rnd req_ready",  64'(req_ready),  64'(e_rdy));
            chk("rnd rsp_valid",  64'(rsp_valid),  64'(m_rv));
            chk("rnd rsp_id",     64'(rsp_id),     64'(m_id));
            chk("rnd rsp_result", 64'(rsp_result), 64'(m_res));
            chk("rnd rsp_flags",  64'(rsp_flags),  64'(m_flg));
            if (!rst) begin
                chk("rnd alu_sel", 64'(alu_sel), (pick >= 0) ? 64'(req_sel[pick]) : 64'(ALU_PASS));
                chk("rnd alu_a",   64'(alu_a),   (pick >= 0) ? 64'(req_a[pick])   : 64'h0);
                chk("rnd alu_b",   64'(alu_b),   (pick >= 0) ? 64'(req_b[pick])   : 64'h0);
            end
            @(posedge clk);
            if (rst) begin
                m_ptr = 0; m_lock = -1; m_rv = 1'b0; m_id = 0; m_res = '0; m_flg = '0;
            end else if (gnt >= 0) begin
                fr     = alu_ref(req_sel[gnt], req_a[gnt], req_b[gnt]);
                m_rv   = 1'b1;
                m_id   = gnt;
                m_res  = fr[31:0];
                m_flg  = fr[35:32];
                m_ptr  = (gnt + 1) % N;
                m_lock = req_lock[gnt] ? gnt : -1;
            end else if (rsp_ready) begin
                m_rv = 1'b0;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
